// File: rtl/float_expand_arbiter.sv
// Burst-limited round-robin arbiter that widens the granted requester's small
// float into a wider float format and registers it behind a valid/ready output.
module float_expand_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned EXP_IN   = 3,
    parameter int unsigned FRAC_IN  = 4,
    parameter int unsigned EXP_OUT  = 8,
    parameter int unsigned FRAC_OUT = 23,
    parameter int unsigned BURST    = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_REQ*(1+EXP_IN+FRAC_IN)-1:0]   in_data,
    input  logic [NUM_REQ-1:0]                      in_valid,
    output logic [NUM_REQ-1:0]                      in_ready,
    output logic [EXP_OUT+FRAC_OUT:0]               out_data,
    output logic [$clog2(NUM_REQ)-1:0]              out_id,
    output logic [3:0]                              out_flags,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [31:0]                             xfer_count
);

    localparam int unsigned IN_W  = 1 + EXP_IN + FRAC_IN;
    localparam int unsigned OUT_W = 1 + EXP_OUT + FRAC_OUT;
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int          BIAS_IN  = int'((1 << (EXP_IN - 1)) - 1);
    localparam int          BIAS_OUT = int'((1 << (EXP_OUT - 1)) - 1);

    logic [ID_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [3:0]          flags_q, flags_d;
    logic [31:0]         count_q, count_d;

    logic                gnt_ok;
    logic [ID_W-1:0]     gnt;
    int                  idx;
    logic                load_c;
    logic                xfer_c;

    // Owner keeps the grant while its burst budget lasts; otherwise scan
    // upward from owner+1 so the owner is considered last.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = owner_q;
        idx    = 0;
        if (in_valid[owner_q] && (int'(cnt_q) < int'(BURST) - 1)) begin
            gnt_ok = 1'b1;
        end else begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                idx = (int'(owner_q) + k) % int'(NUM_REQ);
                if (!gnt_ok && in_valid[ID_W'(idx)]) begin
                    gnt_ok = 1'b1;
                    gnt    = ID_W'(idx);
                end
            end
        end
    end

    assign load_c = ~valid_q | out_ready;
    assign xfer_c = load_c & gnt_ok & ~reset;

    always_comb begin
        in_ready = '0;
        if (xfer_c) in_ready[gnt] = 1'b1;
    end

    logic [IN_W-1:0]     sel_data;
    logic                sgn;
    logic [EXP_IN-1:0]   ein;
    logic [FRAC_IN-1:0]  fin;
    logic [FRAC_OUT-1:0] fpad;
    logic [EXP_OUT-1:0]  exp_x;
    logic [FRAC_OUT-1:0] frac_x;
    logic [3:0]          flags_x;
    int                  lead;
    int                  shift;
    int                  e_norm;

    assign sel_data = in_data[int'(gnt)*int'(IN_W) +: IN_W];

    // Rebias; input denormals become normal when the wider exponent can hold them.
    always_comb begin
        sgn     = sel_data[IN_W-1];
        ein     = sel_data[FRAC_IN +: EXP_IN];
        fin     = sel_data[FRAC_IN-1:0];
        fpad    = FRAC_OUT'(fin) << (FRAC_OUT - FRAC_IN);
        exp_x   = '0;
        frac_x  = fpad;
        flags_x = 4'b0000;
        lead    = 0;
        for (int i = 0; i < int'(FRAC_IN); i++) begin
            if (fin[i]) lead = i;
        end
        shift  = int'(FRAC_IN) - lead;
        e_norm = BIAS_OUT + 1 - BIAS_IN - shift;
        if (ein == '1) begin
            exp_x   = '1;
            flags_x = (fin == '0) ? 4'b1000 : 4'b0100;
        end else if (ein == '0) begin
            if (fin == '0) begin
                flags_x = 4'b0010;
            end else if (e_norm >= 1) begin
                exp_x  = EXP_OUT'(e_norm);
                frac_x = fpad << shift;
            end else begin
                frac_x  = fpad << (BIAS_OUT - BIAS_IN);
                flags_x = 4'b0001;
            end
        end else begin
            exp_x = EXP_OUT'(int'(ein) + BIAS_OUT - BIAS_IN);
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        flags_d = flags_q;
        count_d = count_q;
        if (valid_q && out_ready && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
        if (xfer_c) begin
            valid_d = 1'b1;
            data_d  = {sgn, exp_x, frac_x};
            id_d    = gnt;
            flags_d = flags_x;
            if (gnt == owner_q) begin
                // Saturate so a fallback regrant of the owner stays within range.
                if (int'(cnt_q) < int'(BURST) - 1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                owner_d = gnt;
                cnt_d   = '0;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= ID_W'(NUM_REQ - 1);
            cnt_q   <= CNT_W'(BURST - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            flags_q <= '0;
            count_q <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_id     = id_q;
    assign out_flags  = flags_q;
    assign xfer_count = count_q;

endmodule
